key_debounce_array: RTL

Parametrised N-channel push-button conditioner for the game's control inputs. It replaces per-button fixed debounce instances with one array block.
- Each channel is synchronised, debounced by a 4-state FSM, and produces a debounced level plus single-cycle press and release pulses.
- A compile-time auto-repeat option lets held direction keys generate periodic press pulses.
- It sits between the board pushbuttons and the game control FSM.

---
 rtl/key_pkg.sv | 22 ++
 rtl/key_debounce_ch.sv | 133 +++++++++++++
 rtl/key_debounce_array.sv | 46 ++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types, width helper and 100 MHz timing defaults for the key debounce array.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        HELD       = 2'd2,
        REL_FILT   = 2'd3
    } key_fsm_t;

    localparam int DEF_DEBOUNCE_CYC  = 2_000_000;   // 20 ms
    localparam int DEF_REPEAT_DELAY  = 50_000_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD = 10_000_000;  // 100 ms

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((longint'(1) << r) < longint'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, 4-state debounce FSM, optional auto-repeat (KEY_REPEAT_EN).
// Latency: press/release pulse DEBOUNCE_CYC+3 edges after the first sampling edge; no backpressure, pulses are fire-and-forget.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int KEY_ACTIVE_LEVEL = 1,
    parameter int REPEAT_DELAY     = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD    = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_press_nxt
);

    localparam int            CW      = (clog2(DEBOUNCE_CYC) < 1) ? 1 : clog2(DEBOUNCE_CYC);
    localparam logic          ACT_LVL = (KEY_ACTIVE_LEVEL != 0);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic          act;
    key_fsm_t      state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          accept, release_nxt, rep_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {2{~ACT_LVL}};
        else        sync_q <= {sync_q[0], key_raw};
    end

    assign act = (sync_q[1] == ACT_LVL);

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        accept      = 1'b0;
        release_nxt = 1'b0;
        unique case (state_q)
            IDLE: if (act) begin
                state_nxt = PRESS_FILT;
                cnt_nxt   = '0;
            end
            PRESS_FILT: begin
                if (!act) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    accept    = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            HELD: if (!act) begin
                state_nxt = REL_FILT;
                cnt_nxt   = '0;
            end
            REL_FILT: begin
                if (act) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign key_press_nxt = accept | rep_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            key_press   <= key_press_nxt;
            key_release <= release_nxt;
            if (accept)           key_state <= 1'b1;
            else if (release_nxt) key_state <= 1'b0;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (clog2(RMAX) < 1) ? 1 : clog2(RMAX);

    logic [RW-1:0] rcnt_q, rep_lim;
    logic          rep_phase_q, in_held;

    // rcnt runs through REL_FILT bounces; the release edge itself never repeats.
    assign in_held = (state_q == HELD) || (state_q == REL_FILT);
    assign rep_lim = rep_phase_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    assign rep_hit = in_held && !release_nxt && (rcnt_q == rep_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q      <= '0;
            rep_phase_q <= 1'b0;
        end else if (accept) begin
            rcnt_q      <= '0;
            rep_phase_q <= 1'b0;
        end else if (in_held) begin
            if (rcnt_q == rep_lim) begin
                rcnt_q      <= '0;
                rep_phase_q <= 1'b1;
            end else begin
                rcnt_q <= rcnt_q + 1'b1;
            end
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_array.sv
// N_KEYS independent debounced key channels plus a registered any-press flag (auto-repeat under KEY_REPEAT_EN).
// Latency: DEBOUNCE_CYC+3 edges from first sampling edge to pulse; no backpressure, pulses cannot be stalled.
module key_debounce_array
    import key_pkg::*;
#(
    parameter int N_KEYS           = 5,
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int KEY_ACTIVE_LEVEL = 1,
    parameter int REPEAT_DELAY     = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD    = DEF_REPEAT_PERIOD
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              key_any_press
);

    logic [N_KEYS-1:0] press_nxt;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC    (DEBOUNCE_CYC),
            .KEY_ACTIVE_LEVEL(KEY_ACTIVE_LEVEL),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk          (CLK100MHZ),
            .rst_n        (CPU_RESETN),
            .key_raw      (key_in[i]),
            .key_state    (key_state[i]),
            .key_press    (key_press[i]),
            .key_release  (key_release[i]),
            .key_press_nxt(press_nxt[i])
        );
    end

    // Registered from the same next-state terms so it aligns with key_press.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) key_any_press <= 1'b0;
        else             key_any_press <= |press_nxt;
    end

endmodule
